// File: rtl/spongent_arbiter_if.sv
// Bundles both requester ports and the shared spongent core port of the arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters plus core).
interface spongent_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int N          = 88
);
   logic                  req_0;
   logic                  req_1;
   logic [DATA_WIDTH-1:0] msg_0;
   logic [DATA_WIDTH-1:0] msg_1;
   logic                  ack_0;
   logic                  ack_1;
   logic                  err_0;
   logic                  err_1;
   logic [N-1:0]          hash_0;
   logic [N-1:0]          hash_1;
   logic                  core_rst;
   logic [DATA_WIDTH-1:0] core_msg;
   logic [N-1:0]          core_hash;
   logic                  core_end;
   logic                  busy;
   logic                  grant_id;

   modport slave (
      input  req_0, req_1, msg_0, msg_1, core_hash, core_end,
      output ack_0, ack_1, err_0, err_1, hash_0, hash_1,
             core_rst, core_msg, busy, grant_id
   );

   modport master (
      output req_0, req_1, msg_0, msg_1, core_hash, core_end,
      input  ack_0, ack_1, err_0, err_1, hash_0, hash_1,
             core_rst, core_msg, busy, grant_id
   );
endinterface

// File: rtl/spongent_arbiter.sv
// Round-robin sharing of one spongent hash core between two level requesters.
// Request-to-ack latency is 3 + RUN cycles to core_end; a RUN with no end aborts after TIMEOUT_CYCLES.
module spongent_arbiter #(
   parameter int DATA_WIDTH     = 64,
   parameter int N              = 88,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input logic               clk,
   input logic               rst,
   spongent_arbiter_if.slave bus
);
   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LP_TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t                r_state;
   logic                  r_core_rst;
   logic                  r_grant_id;
   logic                  r_last_grant;
   logic                  r_err_flag;
   logic                  r_ack_0;
   logic                  r_ack_1;
   logic [DATA_WIDTH-1:0] r_core_msg;
   logic [N-1:0]          r_hash_0;
   logic [N-1:0]          r_hash_1;
   logic [CW-1:0]         r_cnt;

   logic                  w_grant_vld;
   logic                  w_grant_sel;
   logic                  w_timeout;

   // On contention the requester that was not served last wins.
   always_comb begin
      w_grant_vld = bus.req_0 | bus.req_1;
      if (bus.req_0 && bus.req_1) begin
         w_grant_sel = ~r_last_grant;
      end else begin
         w_grant_sel = bus.req_1;
      end
   end

   assign w_timeout = (r_cnt == LP_TMAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_core_rst   <= 1'b1;
         r_core_msg   <= '0;
         r_ack_0      <= 1'b0;
         r_ack_1      <= 1'b0;
         r_hash_0     <= '0;
         r_hash_1     <= '0;
         r_grant_id   <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_err_flag   <= 1'b0;
      end else begin
         r_ack_0 <= 1'b0;
         r_ack_1 <= 1'b0;
         case (r_state)
            IDLE: begin
               r_core_rst <= 1'b1;
               if (w_grant_vld) begin
                  r_grant_id <= w_grant_sel;
                  r_core_msg <= w_grant_sel ? bus.msg_1 : bus.msg_0;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               r_cnt      <= '0;
               r_core_rst <= 1'b0;
               r_state    <= RUN;
            end
            RUN: begin
               // core_end is checked first so a coincident timeout still succeeds.
               if (bus.core_end) begin
                  if (r_grant_id) begin
                     r_hash_1 <= bus.core_hash;
                  end else begin
                     r_hash_0 <= bus.core_hash;
                  end
                  r_err_flag <= 1'b0;
                  r_ack_0    <= ~r_grant_id;
                  r_ack_1    <= r_grant_id;
                  r_core_rst <= 1'b1;
                  r_state    <= DONE;
               end else if (w_timeout) begin
                  r_err_flag <= 1'b1;
                  r_ack_0    <= ~r_grant_id;
                  r_ack_1    <= r_grant_id;
                  r_core_rst <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               r_last_grant <= r_grant_id;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack_0    = r_ack_0;
   assign bus.ack_1    = r_ack_1;
   assign bus.err_0    = r_ack_0 & r_err_flag;
   assign bus.err_1    = r_ack_1 & r_err_flag;
   assign bus.hash_0   = r_hash_0;
   assign bus.hash_1   = r_hash_1;
   assign bus.core_rst = r_core_rst;
   assign bus.core_msg = r_core_msg;
   assign bus.busy     = (r_state != IDLE);
   assign bus.grant_id = r_grant_id;
endmodule
